// File: rtl/msk_sbox_sched.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : msk_sbox_sched
// Purpose  : Time-multiplexes one shared masked S-box pipeline (HPC3 gadgets,
//            fixed latency LAT, no enable, no reset) across the bytes of a
//            d-share masked word. One byte is issued per cycle, and only when
//            fresh PRNG randomness is offered. In-flight bytes are tracked by
//            tag, and the results are reassembled into a masked output word.
//            Shares are only wired and registered; they are never recombined.
// Options  : define MSK_SCHED_ZEROIZE_EN to zero sbox_in on non-issue cycles,
//            clear the word register when the last byte issues, and clear
//            out_data on the HOLD->IDLE transition.
// Revision : 1.0 - initial release
// ============================================================================
module msk_sbox_sched #(
  parameter int D      = 2,  // number of shares
  parameter int NBYTES = 4,  // bytes per word (>= 2)
  parameter int LAT    = 4   // S-box pipeline latency in cycles (>= 1)
) (
  input  logic                    clk,
  input  logic                    syn_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*D*NBYTES-1:0]   in_data,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  output logic [8*D-1:0]          sbox_in,
  output logic                    sbox_issue,
  input  logic [8*D-1:0]          sbox_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*D*NBYTES-1:0]   out_data
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BW = 8 * D;
  localparam int WW = BW * NBYTES;

  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    word_q, word_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [LAT*CW-1:0] idx_q, idx_d;
  logic [WW-1:0]    out_data_q, out_data_d;

  logic             w_issue;
  logic             w_in_fire;
  logic [LAT-1:0]   w_vld_shift;
  logic [LAT*CW-1:0] w_idx_shift;
  logic             w_tail_vld;
  logic [CW-1:0]    w_tail_idx;

  // Tag pipeline: stage 0 takes {issue, cnt} every cycle, the tail marks
  // which output slice the S-box result belongs to.
  if (LAT == 1) begin : g_pipe_single
    assign w_vld_shift = w_issue;
    assign w_idx_shift = cnt_q;
  end else begin : g_pipe_multi
    assign w_vld_shift = {vld_q[LAT-2:0], w_issue};
    assign w_idx_shift = {idx_q[(LAT-1)*CW-1:0], cnt_q};
  end

  assign w_tail_vld = vld_q[LAT-1];
  assign w_tail_idx = idx_q[(LAT-1)*CW +: CW];
  assign w_in_fire  = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DRAIN looks at the next tag-pipe value, so HOLD starts
  // in the cycle right after the last byte has been captured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_in_fire) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_issue && (cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_vld_shift == '0) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = w_in_fire ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake strobes and the issue strobe.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_issue   = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_ISSUE: w_issue  = rnd_valid;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign rnd_ready  = w_issue;
  assign sbox_issue = w_issue;
  assign out_data   = out_data_q;

  // Byte mux towards the S-box.
  always_comb begin
`ifdef MSK_SCHED_ZEROIZE_EN
    sbox_in = w_issue ? word_q[BW*cnt_q +: BW] : '0;
`else
    sbox_in = word_q[BW*cnt_q +: BW];
`endif
  end

  // Datapath next state: word load, byte counter, tag shift and result capture.
  always_comb begin
    word_d     = word_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    vld_d      = w_vld_shift;
    idx_d      = w_idx_shift;

    if (w_in_fire) begin
      word_d = in_data;
      cnt_d  = '0;
    end

    // The counter returns to 0 after the last byte so it never leaves the
    // range 0..NBYTES-1.
    if (w_issue) begin
      if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
`ifdef MSK_SCHED_ZEROIZE_EN
        word_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Results land in the slice named by their tag, not by arrival order.
    if (w_tail_vld) begin
      out_data_d[BW*w_tail_idx +: BW] = sbox_out;
    end

`ifdef MSK_SCHED_ZEROIZE_EN
    if ((state_q == S_HOLD) && out_ready && !w_in_fire) begin
      out_data_d = '0;
    end
`endif
  end

  // Datapath registers. Clearing the tag pipe on reset makes any S-box
  // results still in flight be ignored.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      word_q     <= '0;
      cnt_q      <= '0;
      vld_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/msk_sbox_sched.md
Name: msk_sbox_sched

Overview:
- Scheduler that time-multiplexes one shared masked S-box pipeline across the bytes of a masked word.
- The pipeline is built from HPC3 AND gadgets and has no enable and no reset.
- Accepts a d-share masked word, issues one byte per cycle only when fresh PRNG randomness is available, tracks in-flight bytes, and reassembles results into a masked output word.
- Sits between the round datapath and the S-box instance in the 32-bit masked AES core.

Parameters:
- d, 2, number of shares.
- NBYTES, 4, bytes per word (>=2).
- LAT, 4, S-box pipeline latency in cycles (>=1).
- CW, max(1,clog2(NBYTES)), byte index width (localparam).

Ports:
- clk  input  1  clock, rising edge.
- syn_rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  scheduler can accept a word.
- in_data  input  8*d*NBYTES  masked word; byte k at [8*d*k +: 8*d], share layout passed through untouched.
- rnd_valid  input  1  PRNG randomness for one S-box issue available this cycle.
- rnd_ready  output  1  randomness consumed this cycle (equals issue strobe).
- sbox_in  output  8*d  masked byte driven to the S-box.
- sbox_issue  output  1  a byte is issued to the S-box this cycle.
- sbox_out  input  8*d  S-box result, LAT cycles after issue.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  8*d*NBYTES  masked result word, same byte layout as in_data.

Behaviour:
- Clock and reset: one clock clk. Reset syn_rst is synchronous, active-high, and has priority over all other events.
- Reset values: state=IDLE, cnt=0, valid pipe=0, out_valid=0, out_data=0, word register=0, in_ready=1.
- Reset mid-operation:
  - All in-flight bytes are abandoned.
  - S-box results arriving after reset are ignored, because the valid pipe has been cleared.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load the word register, cnt<=0, go to ISSUE.
- State ISSUE, issue rule:
  - issue = rnd_valid in this state, else 0. rnd_ready=issue, sbox_issue=issue.
  - sbox_in = byte cnt of the word register (combinational, same cycle).
  - On issue: cnt<=cnt+1. If cnt==NBYTES-1, go to DRAIN.
- State ISSUE, stall: if rnd_valid=0, there is no issue and cnt holds (bubble). Bubbles are allowed between any bytes.
- Tracking:
  - LAT-deep shift register of {valid,index}; stage 0 loads {issue,cnt} every cycle.
  - When the tail is valid, out_data slice [index] <= sbox_out at the end of that cycle.
  - A byte issued in cycle t is captured at the end of t+LAT.
- State DRAIN: when the valid pipe is all-zero (last byte captured), go to HOLD.
- State HOLD:
  - out_valid=1 and out_data is stable.
  - On out_ready: go to IDLE, unless a new word is accepted in the same cycle, in which case go directly to ISSUE.
- in_ready rule: in_ready = (state==IDLE) || (state==HOLD && out_ready).
- Timing: with no stalls, a word accepted at the edge ending cycle T issues in T+1..T+NBYTES, and out_valid first rises in cycle T+NBYTES+LAT+1. For defaults that is T+9.
- Ordering: bytes are issued in increasing index; out_data slices are written by tag, never by arrival count.
- Throughput: at most one word in flight; no overlap of ISSUE with DRAIN/HOLD of the previous word.
- Arithmetic: cnt is CW bits and never wraps past NBYTES-1. The share-wise datapath is pure wiring/registers; no share recombination anywhere.
- Boundary cases:
  - in_valid in ISSUE/DRAIN: ignored, in_ready=0.
  - rnd_valid outside ISSUE: not consumed, rnd_ready=0.
  - out_ready outside HOLD: no effect.

Optional Feature:
- Macro: MSK_SCHED_ZEROIZE_EN.
- Defined:
  - sbox_in is driven to all-zero in every cycle without issue.
  - The word register is cleared to zero in the cycle the last byte issues.
  - out_data is cleared to zero on the HOLD->IDLE transition.
  - This limits share lifetime and glitch exposure.
- Undefined:
  - sbox_in shows byte cnt of the word register in all cycles (cnt=0 when idle).
  - The word register and out_data hold their values until overwritten.

Test Plan:
- Reset, then in_data bytes {0x11..,0x22..,0x33..,0x44..} with rnd_valid=1 and S-box model of latency 4 -> sbox_issue in cycles T+1..T+4 with bytes 0..3 in order; out_valid at T+9; out_data = model(in) per byte.
- Same word with rnd_valid low in cycles T+2 and T+3 -> rnd_ready=0 and no issue in those cycles; out_valid delayed to T+11; data correct.
- out_ready held low for 5 cycles in HOLD -> out_valid and out_data stable; in_ready=0. Then out_ready=1 with in_valid=1 -> new word accepted in that cycle; the next cycle is ISSUE with byte 0.
- syn_rst asserted during ISSUE after 2 issues -> next cycle state IDLE, in_ready=1, out_valid=0; late S-box outputs do not alter out_data; the following word completes correctly.
- in_valid pulsed during DRAIN -> not accepted (in_ready=0); rnd_ready never high outside ISSUE.
- With MSK_SCHED_ZEROIZE_EN: sbox_in==0 on all non-issue cycles and out_data==0 after handshake. Without it: sbox_in equals the held byte.
